// File: rtl/dvi_tmds_encoder.sv
// DVI 1.0 TMDS encoder: RGB + syncs to three DC-balanced 10-bit symbols.
// Two-stage pipeline: stage 1 minimises transitions, stage 2 balances DC or emits control tokens.
module dvi_tmds_encoder #(
  parameter logic HS_INV = 1'b0,
  parameter logic VS_INV = 1'b0
) (
  input  logic        vga_clk,
  input  logic        sys_rst_n,
  input  logic        rgb_valid,
  input  logic        hsync,
  input  logic        vsync,
  input  logic [23:0] rgb,
  output logic [9:0]  tmds_r,
  output logic [9:0]  tmds_g,
  output logic [9:0]  tmds_b,
  output logic        de_out
);

  localparam logic [9:0] Tok00 = 10'h354;
  localparam logic [9:0] Tok01 = 10'h0AB;
  localparam logic [9:0] Tok10 = 10'h154;
  localparam logic [9:0] Tok11 = 10'h2AB;

  // Channel index: 0 = blue, 1 = green, 2 = red
  logic [8:0]        w_qm      [3];
  logic [8:0]        r_qm      [3];
  logic [3:0]        r_n1q     [3];
  logic              r_de;
  logic [1:0]        r_ctl;
  logic signed [4:0] w_diff    [3];
  logic signed [4:0] w_cnt_d   [3];
  logic signed [4:0] r_cnt     [3];
  logic [9:0]        w_sym_d   [3];
  logic [9:0]        r_sym     [3];
  logic              r_de2;

  function automatic logic [3:0] f_pop8(input logic [7:0] d);
    logic [3:0] n;
    n = '0;
    for (int i = 0; i < 8; i++) n = n + {3'b000, d[i]};
    return n;
  endfunction

  function automatic logic [8:0] f_qm(input logic [7:0] d);
    logic [8:0] q;
    logic [3:0] n1;
    logic       use_xnor;
    n1       = f_pop8(d);
    use_xnor = (n1 > 4'd4) || ((n1 == 4'd4) && !d[0]);
    q        = '0;
    q[0]     = d[0];
    for (int i = 1; i < 8; i++) q[i] = use_xnor ? ~(q[i-1] ^ d[i]) : (q[i-1] ^ d[i]);
    q[8] = ~use_xnor;
    return q;
  endfunction

  function automatic logic [9:0] f_tok(input logic [1:0] c);
    logic [9:0] t;
    unique case (c)
      2'b00:   t = Tok00;
      2'b01:   t = Tok01;
      2'b10:   t = Tok10;
      default: t = Tok11;
    endcase
    return t;
  endfunction

  always_comb begin
    for (int ch = 0; ch < 3; ch++) w_qm[ch] = f_qm(rgb[8*ch +: 8]);
  end

  always_ff @(posedge vga_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      for (int ch = 0; ch < 3; ch++) begin
        r_qm[ch]  <= '0;
        r_n1q[ch] <= '0;
      end
      r_de  <= 1'b0;
      r_ctl <= 2'b00;
    end else begin
      for (int ch = 0; ch < 3; ch++) begin
        r_qm[ch]  <= w_qm[ch];
        r_n1q[ch] <= f_pop8(w_qm[ch][7:0]);
      end
      r_de  <= rgb_valid;
      r_ctl <= {vsync ^ VS_INV, hsync ^ HS_INV};
    end
  end

  always_comb begin
    for (int ch = 0; ch < 3; ch++) begin
      // n1q - n0q == 2*n1q - 8, range -8..8
      w_diff[ch]  = $signed({r_n1q[ch], 1'b0} - 5'd8);
      w_sym_d[ch] = Tok00;
      w_cnt_d[ch] = '0;
      if (r_de) begin
        if ((r_cnt[ch] == 5'sd0) || (r_n1q[ch] == 4'd4)) begin
          w_sym_d[ch] = {~r_qm[ch][8], r_qm[ch][8],
                         r_qm[ch][8] ? r_qm[ch][7:0] : ~r_qm[ch][7:0]};
          w_cnt_d[ch] = r_qm[ch][8] ? (r_cnt[ch] + w_diff[ch]) : (r_cnt[ch] - w_diff[ch]);
        end else if ((!r_cnt[ch][4] && (r_n1q[ch] > 4'd4)) ||
                     (r_cnt[ch][4] && (r_n1q[ch] < 4'd4))) begin
          w_sym_d[ch] = {1'b1, r_qm[ch][8], ~r_qm[ch][7:0]};
          w_cnt_d[ch] = r_cnt[ch] + $signed({3'b000, r_qm[ch][8], 1'b0}) - w_diff[ch];
        end else begin
          w_sym_d[ch] = {1'b0, r_qm[ch][8], r_qm[ch][7:0]};
          w_cnt_d[ch] = r_cnt[ch] - $signed({3'b000, ~r_qm[ch][8], 1'b0}) + w_diff[ch];
        end
      end else if (ch == 0) begin
        w_sym_d[ch] = f_tok(r_ctl);
      end
    end
  end

  always_ff @(posedge vga_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      for (int ch = 0; ch < 3; ch++) begin
        r_sym[ch] <= Tok00;
        r_cnt[ch] <= '0;
      end
      r_de2 <= 1'b0;
    end else begin
      for (int ch = 0; ch < 3; ch++) begin
        r_sym[ch] <= w_sym_d[ch];
        r_cnt[ch] <= w_cnt_d[ch];
      end
      r_de2 <= r_de;
    end
  end

  assign tmds_b = r_sym[0];
  assign tmds_g = r_sym[1];
  assign tmds_r = r_sym[2];
  assign de_out = r_de2;

endmodule

// File: tb/tb_dvi_tmds_encoder.sv
// Bench for dvi_tmds_encoder: directed vector table, random lines against a
// behavioural TMDS model, sync-inversion instance and mid-line async reset.
module tb_dvi_tmds_encoder;

  logic        vga_clk = 1'b0;
  logic        sys_rst_n;
  logic        rgb_valid;
  logic        hsync;
  logic        vsync;
  logic [23:0] rgb;
  logic [9:0]  r0, g0, b0, r1, g1, b1;
  logic        de0, de1;

  always #5 vga_clk = ~vga_clk;

  dvi_tmds_encoder dut0 (
    .vga_clk  (vga_clk),
    .sys_rst_n(sys_rst_n),
    .rgb_valid(rgb_valid),
    .hsync    (hsync),
    .vsync    (vsync),
    .rgb      (rgb),
    .tmds_r   (r0),
    .tmds_g   (g0),
    .tmds_b   (b0),
    .de_out   (de0)
  );

  dvi_tmds_encoder #(.HS_INV(1'b1), .VS_INV(1'b1)) dut1 (
    .vga_clk  (vga_clk),
    .sys_rst_n(sys_rst_n),
    .rgb_valid(rgb_valid),
    .hsync    (hsync),
    .vsync    (vsync),
    .rgb      (rgb),
    .tmds_r   (r1),
    .tmds_g   (g1),
    .tmds_b   (b1),
    .de_out   (de1)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [9:0] act, input logic [9:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: previous-cycle sample plus running disparity per channel
  logic [9:0]  tok [4] = '{10'h354, 10'h0AB, 10'h154, 10'h2AB};
  int          m_cnt [3];
  logic        m_pde;
  logic [1:0]  m_pc0, m_pc1;
  logic [23:0] m_prgb;
  logic [9:0]  e_sym [3];
  logic [9:0]  e_b1;
  logic        e_de;
  int          run [3];

  task automatic enc(input logic [7:0] d, inout int cnt, output logic [9:0] sym);
    int         n1d, n1q, n0q, q8;
    logic [8:0] qm;
    bit         xn;
    n1d   = $countones(d);
    xn    = (n1d > 4) || (n1d == 4 && d[0] == 1'b0);
    qm[0] = d[0];
    for (int i = 1; i < 8; i++) qm[i] = xn ? !(qm[i-1] ^ d[i]) : (qm[i-1] ^ d[i]);
    qm[8] = !xn;
    q8    = xn ? 0 : 1;
    n1q   = $countones(qm[7:0]);
    n0q   = 8 - n1q;
    if (cnt == 0 || n1q == n0q) begin
      sym = {~qm[8], qm[8], qm[8] ? qm[7:0] : ~qm[7:0]};
      cnt += (q8 == 1) ? (n1q - n0q) : (n0q - n1q);
    end else if ((cnt > 0 && n1q > n0q) || (cnt < 0 && n0q > n1q)) begin
      sym = {1'b1, qm[8], ~qm[7:0]};
      cnt += 2 * q8 + n0q - n1q;
    end else begin
      sym = {1'b0, qm[8], qm[7:0]};
      cnt += n1q - n0q - 2 * (1 - q8);
    end
  endtask

  task automatic model_reset();
    m_pde  = 1'b0;
    m_pc0  = 2'b00;
    m_pc1  = 2'b00;
    m_prgb = '0;
    for (int ch = 0; ch < 3; ch++) begin
      m_cnt[ch] = 0;
      run[ch]   = 0;
    end
  endtask

  task automatic model_advance(input logic de, input logic hs, input logic vs,
                               input logic [23:0] d);
    if (m_pde) begin
      for (int ch = 0; ch < 3; ch++) enc(m_prgb[8*ch +: 8], m_cnt[ch], e_sym[ch]);
      e_b1 = e_sym[0];
    end else begin
      for (int ch = 0; ch < 3; ch++) m_cnt[ch] = 0;
      e_sym[2] = 10'h354;
      e_sym[1] = 10'h354;
      e_sym[0] = tok[m_pc0];
      e_b1     = tok[m_pc1];
    end
    e_de   = m_pde;
    m_pde  = de;
    m_prgb = d;
    m_pc0  = {vs, hs};
    m_pc1  = {~vs, ~hs};
  endtask

  task automatic step(input logic de, input logic hs, input logic vs, input logic [23:0] d);
    rgb_valid = de;
    hsync     = hs;
    vsync     = vs;
    rgb       = d;
    @(posedge vga_clk);
    #1;
    model_advance(de, hs, vs, d);
  endtask

  task automatic compare_model(input string tag);
    logic [9:0] act [3];
    int         a;
    act[0] = b0;
    act[1] = g0;
    act[2] = r0;
    check({tag, "_r"}, r0, e_sym[2]);
    check({tag, "_g"}, g0, e_sym[1]);
    check({tag, "_b"}, b0, e_sym[0]);
    check({tag, "_de"}, {9'b0, de0}, {9'b0, e_de});
    check({tag, "_inv_b"}, b1, e_b1);
    check({tag, "_inv_r"}, r1, e_sym[2]);
    check({tag, "_inv_de"}, {9'b0, de1}, {9'b0, e_de});
    for (int ch = 0; ch < 3; ch++) begin
      if (de0) run[ch] += 2 * $countones(act[ch]) - 10;
      else     run[ch] = 0;
      a = (run[ch] < 0) ? -run[ch] : run[ch];
      n_checks++;
      if (a > 10) begin
        n_errors++;
        $display("FAIL %s_disparity ch%0d: got %0d, expected |d|<=10", tag, ch, run[ch]);
      end
    end
  endtask

  typedef struct {
    logic        de, hs, vs;
    logic [23:0] d;
    logic [9:0]  er, eg, eb, eb1;
    logic        ede;
  } vec_t;

  vec_t vecs [15];

  initial begin
    // Expected outputs in row i come from the inputs of row i-1
    vecs[0]  = '{1'b0, 1'b1, 1'b0, 24'h000000, 10'h354, 10'h354, 10'h354, 10'h354, 1'b0};
    vecs[1]  = '{1'b0, 1'b1, 1'b0, 24'h000000, 10'h354, 10'h354, 10'h0AB, 10'h154, 1'b0};
    vecs[2]  = '{1'b0, 1'b1, 1'b0, 24'h123456, 10'h354, 10'h354, 10'h0AB, 10'h154, 1'b0};
    vecs[3]  = '{1'b0, 1'b1, 1'b0, 24'h000000, 10'h354, 10'h354, 10'h0AB, 10'h154, 1'b0};
    vecs[4]  = '{1'b1, 1'b0, 1'b0, 24'h000000, 10'h354, 10'h354, 10'h0AB, 10'h154, 1'b0};
    vecs[5]  = '{1'b1, 1'b0, 1'b0, 24'h000000, 10'h100, 10'h100, 10'h100, 10'h100, 1'b1};
    vecs[6]  = '{1'b1, 1'b0, 1'b0, 24'h000000, 10'h3FF, 10'h3FF, 10'h3FF, 10'h3FF, 1'b1};
    vecs[7]  = '{1'b0, 1'b0, 1'b0, 24'hA5A5A5, 10'h100, 10'h100, 10'h100, 10'h100, 1'b1};
    vecs[8]  = '{1'b1, 1'b0, 1'b0, 24'hFFFFFF, 10'h354, 10'h354, 10'h354, 10'h2AB, 1'b0};
    vecs[9]  = '{1'b1, 1'b0, 1'b0, 24'h000000, 10'h200, 10'h200, 10'h200, 10'h200, 1'b1};
    vecs[10] = '{1'b0, 1'b0, 1'b1, 24'h5A5A5A, 10'h3FF, 10'h3FF, 10'h3FF, 10'h3FF, 1'b1};
    vecs[11] = '{1'b0, 1'b1, 1'b1, 24'h000000, 10'h354, 10'h354, 10'h154, 10'h0AB, 1'b0};
    vecs[12] = '{1'b0, 1'b1, 1'b0, 24'h000000, 10'h354, 10'h354, 10'h2AB, 10'h354, 1'b0};
    vecs[13] = '{1'b0, 1'b0, 1'b0, 24'h000000, 10'h354, 10'h354, 10'h0AB, 10'h154, 1'b0};
    vecs[14] = '{1'b0, 1'b0, 1'b0, 24'h000000, 10'h354, 10'h354, 10'h354, 10'h2AB, 1'b0};

    sys_rst_n = 1'b0;
    rgb_valid = 1'b0;
    hsync     = 1'b0;
    vsync     = 1'b0;
    rgb       = '0;
    model_reset();
    #12;
    check("reset_r", r0, 10'h354);
    check("reset_g", g0, 10'h354);
    check("reset_b", b0, 10'h354);
    check("reset_inv_b", b1, 10'h354);
    check("reset_de", {9'b0, de0}, 10'h000);
    sys_rst_n = 1'b1;

    for (int i = 0; i < 15; i++) begin
      step(vecs[i].de, vecs[i].hs, vecs[i].vs, vecs[i].d);
      check($sformatf("vec%0d_r", i), r0, vecs[i].er);
      check($sformatf("vec%0d_g", i), g0, vecs[i].eg);
      check($sformatf("vec%0d_b", i), b0, vecs[i].eb);
      check($sformatf("vec%0d_inv_b", i), b1, vecs[i].eb1);
      check($sformatf("vec%0d_inv_g", i), g1, vecs[i].eg);
      check($sformatf("vec%0d_de", i), {9'b0, de0}, {9'b0, vecs[i].ede});
      check($sformatf("vec%0d_inv_de", i), {9'b0, de1}, {9'b0, vecs[i].ede});
    end

    for (int l = 0; l < 8; l++) begin
      int nb;
      int na;
      nb = $urandom_range(3, 8);
      na = $urandom_range(40, 100);
      for (int b = 0; b < nb; b++) begin
        step(1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 24'($urandom()));
        compare_model($sformatf("line%0d_blank%0d", l, b));
      end
      for (int a = 0; a < na; a++) begin
        step(1'b1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 24'($urandom()));
        compare_model($sformatf("line%0d_pix%0d", l, a));
      end
    end

    for (int a = 0; a < 12; a++) begin
      step(1'b1, 1'b0, 1'b0, 24'($urandom()));
      compare_model($sformatf("prerst_pix%0d", a));
    end
    #2;
    sys_rst_n = 1'b0;
    #1;
    check("midrst_r", r0, 10'h354);
    check("midrst_g", g0, 10'h354);
    check("midrst_b", b0, 10'h354);
    check("midrst_inv_b", b1, 10'h354);
    check("midrst_de", {9'b0, de0}, 10'h000);
    model_reset();
    @(posedge vga_clk);
    #1;
    sys_rst_n = 1'b1;
    for (int a = 0; a < 20; a++) begin
      step(1'b1, 1'b0, 1'b0, 24'($urandom()));
      compare_model($sformatf("postrst_pix%0d", a));
    end
    for (int b = 0; b < 4; b++) begin
      step(1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 24'h0);
      compare_model($sformatf("tail_blank%0d", b));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
